rob_queue: RTL and testbench

- Circular reorder buffer that produces the in-order head stream consumed by the commit stage.
- Accepts in-order dispatch of instructions and allocates a tag per entry.
- Marks entries complete when the common data bus (CDB) broadcasts a result.
- Presents the oldest entry (valid/ready/opcode/rd/value) to commit; commit retires it with a pop.

---
 rtl/rob_queue.sv | 114 +++++++++++
 tb/tb_rob_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_queue.sv
`default_nettype none
// ============================================================================
// Module      : rob_queue
// Description : Circular reorder buffer. In-order dispatch allocates tags,
//               CDB broadcasts complete entries, the head is exposed to commit.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_queue #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dispatch_valid,
  input  logic [6:0]        dispatch_opcode,
  input  logic [4:0]        dispatch_rd,
  output logic              dispatch_ready,
  output logic [IDX_W-1:0]  dispatch_idx,
  input  logic              cdb_valid,
  input  logic [IDX_W-1:0]  cdb_idx,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              rob_valid,
  output logic              rob_ready,
  output logic [6:0]        commit_opcode,
  output logic [4:0]        commit_rd,
  output logic [DATA_W-1:0] commit_value,
  output logic [IDX_W-1:0]  commit_idx,
  input  logic              rob_pop,
  output logic [IDX_W:0]    rob_count
);

  localparam logic [IDX_W:0] c_ptr_one = {{IDX_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]    r_head;
  logic [IDX_W:0]    r_tail;
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_ready;
  logic [6:0]        r_opcode [DEPTH];
  logic [4:0]        r_rd     [DEPTH];
  logic [DATA_W-1:0] r_value  [DEPTH];

  logic [IDX_W-1:0]  w_head_idx;
  logic [IDX_W-1:0]  w_tail_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_cdb;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

  assign dispatch_ready = !w_full;
  assign dispatch_idx   = w_tail_idx;
  assign rob_valid      = !w_empty;
  assign rob_ready      = rob_valid && r_ready[w_head_idx];
  assign commit_opcode  = r_opcode[w_head_idx];
  assign commit_rd      = r_rd[w_head_idx];
  assign commit_value   = r_value[w_head_idx];
  assign commit_idx     = w_head_idx;
  assign rob_count      = r_tail - r_head;

  // Dispatch, writeback and retire never touch the same slot in one cycle:
  // the tail slot is free whenever a push happens, and the head is already ready.
  assign w_push = dispatch_valid && !w_full && !flush;
  assign w_pop  = rob_pop && rob_ready && !flush;
  assign w_cdb  = cdb_valid && r_valid[cdb_idx] && !r_ready[cdb_idx] && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_ready <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_ready <= '0;
    end else begin
      if (w_pop) begin
        r_valid[w_head_idx] <= 1'b0;
        r_ready[w_head_idx] <= 1'b0;
        r_head              <= r_head + c_ptr_one;
      end
      if (w_cdb) begin
        r_ready[cdb_idx] <= 1'b1;
      end
      if (w_push) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_ready[w_tail_idx] <= 1'b0;
        r_tail              <= r_tail + c_ptr_one;
      end
    end
  end

  // Payload is qualified by the valid/ready bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_opcode[w_tail_idx] <= dispatch_opcode;
      r_rd[w_tail_idx]     <= dispatch_rd;
    end
    if (w_cdb) begin
      r_value[cdb_idx] <= cdb_value;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_queue
// Description : Directed self-checking bench for rob_queue with a tag scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_queue;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              dispatch_valid = 1'b0;
  logic [6:0]        dispatch_opcode = '0;
  logic [4:0]        dispatch_rd = '0;
  logic              dispatch_ready;
  logic [IDX_W-1:0]  dispatch_idx;
  logic              cdb_valid = 1'b0;
  logic [IDX_W-1:0]  cdb_idx = '0;
  logic [DATA_W-1:0] cdb_value = '0;
  logic              rob_valid;
  logic              rob_ready;
  logic [6:0]        commit_opcode;
  logic [4:0]        commit_rd;
  logic [DATA_W-1:0] commit_value;
  logic [IDX_W-1:0]  commit_idx;
  logic              rob_pop = 1'b0;
  logic [IDX_W:0]    rob_count;

  always #5 clk = ~clk;

  rob_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
    .dispatch_rd(dispatch_rd), .dispatch_ready(dispatch_ready),
    .dispatch_idx(dispatch_idx), .cdb_valid(cdb_valid), .cdb_idx(cdb_idx),
    .cdb_value(cdb_value), .rob_valid(rob_valid), .rob_ready(rob_ready),
    .commit_opcode(commit_opcode), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_idx(commit_idx),
    .rob_pop(rob_pop), .rob_count(rob_count)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard: tags in allocation order plus per-tag expected contents.
  int                q[$];
  logic              m_valid [DEPTH];
  logic              m_ready [DEPTH];
  logic [6:0]        m_op    [DEPTH];
  logic [4:0]        m_rd    [DEPTH];
  logic [DATA_W-1:0] m_val   [DEPTH];
  logic [IDX_W:0]    m_head;
  logic [IDX_W:0]    m_tail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_head = '0;
    m_tail = '0;
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ready[i] = 1'b0;
    end
  endtask

  task automatic check_state();
    logic exp_rdy;
    exp_rdy = 1'b0;
    if (q.size() > 0) exp_rdy = m_ready[q[0]];
    chk("rob_valid", 64'(rob_valid), 64'(q.size() != 0));
    chk("rob_ready", 64'(rob_ready), 64'(exp_rdy));
    chk("dispatch_ready", 64'(dispatch_ready), 64'(q.size() < DEPTH));
    chk("dispatch_idx", 64'(dispatch_idx), 64'(m_tail[IDX_W-1:0]));
    chk("rob_count", 64'(rob_count), 64'(q.size()));
    chk("commit_idx", 64'(commit_idx), 64'(m_head[IDX_W-1:0]));
  endtask

  task automatic cycle(input logic dv, input logic [6:0] op, input logic [4:0] rd,
                       input logic cv, input logic [IDX_W-1:0] ci,
                       input logic [DATA_W-1:0] cval, input logic pop, input logic fl);
    logic push_ok, pop_ok, cdb_ok;
    logic [IDX_W-1:0] tt;
    int t;
    push_ok = dv && (q.size() < DEPTH);
    pop_ok  = 1'b0;
    if (pop && q.size() > 0) pop_ok = m_ready[q[0]];
    cdb_ok  = cv && m_valid[ci] && !m_ready[ci];
    if (pop_ok) begin
      t = q[0];
      chk("commit_idx_pop", 64'(commit_idx), 64'(t));
      chk("commit_opcode", 64'(commit_opcode), 64'(m_op[t]));
      chk("commit_rd", 64'(commit_rd), 64'(m_rd[t]));
      chk("commit_value", 64'(commit_value), 64'(m_val[t]));
    end
    dispatch_valid = dv; dispatch_opcode = op; dispatch_rd = rd;
    cdb_valid = cv; cdb_idx = ci; cdb_value = cval;
    rob_pop = pop; flush = fl;
    @(posedge clk);
    #1;
    dispatch_valid = 1'b0; cdb_valid = 1'b0; rob_pop = 1'b0; flush = 1'b0;
    if (fl) begin
      model_reset();
    end else begin
      if (pop_ok) begin
        t = q.pop_front();
        m_valid[t] = 1'b0;
        m_ready[t] = 1'b0;
        m_head++;
      end
      if (cdb_ok) begin
        m_ready[ci] = 1'b1;
        m_val[ci]   = cval;
      end
      if (push_ok) begin
        tt = m_tail[IDX_W-1:0];
        m_valid[tt] = 1'b1;
        m_ready[tt] = 1'b0;
        m_op[tt]    = op;
        m_rd[tt]    = rd;
        q.push_back(int'(tt));
        m_tail++;
      end
    end
    check_state();
  endtask

  task automatic disp(input logic [6:0] op, input logic [4:0] rd);
    cycle(1'b1, op, rd, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic cdb(input logic [IDX_W-1:0] ci, input logic [DATA_W-1:0] v);
    cycle(1'b0, '0, '0, 1'b1, ci, v, 1'b0, 1'b0);
  endtask

  task automatic pop_c();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [IDX_W-1:0] prev, nxt;
    int t;

    // Reset and idle; a pop on an empty buffer is ignored.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state();
    pop_c();

    // Out-of-order completion, in-order retirement.
    disp(7'h33, 5'd1);
    disp(7'h23, 5'd0);
    disp(7'h63, 5'd0);
    cdb(4'd1, 32'hAA);
    chk("head_not_ready", 64'(rob_ready), 64'(0));
    cdb(4'd0, 32'h55);
    chk("head_ready", 64'(rob_ready), 64'(1));
    chk("head_value", 64'(commit_value), 64'h55);
    pop_c();
    chk("second_opcode", 64'(commit_opcode), 64'h23);
    chk("second_value", 64'(commit_value), 64'hAA);
    pop_c();
    pop_c();
    chk("wait_tag2", 64'(rob_count), 64'(1));
    cdb(4'd2, 32'h77);
    pop_c();

    // Fill to full, overflow attempt, then steady pop+dispatch across a wrap.
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) disp(7'($urandom), 5'($urandom));
    chk("full_ready", 64'(dispatch_ready), 64'(0));
    chk("full_count", 64'(rob_count), 64'(16));
    disp(7'h7F, 5'd31);
    for (int i = 0; i < DEPTH; i++) cdb(IDX_W'(q[i]), $urandom);
    chk("wrap_tag", 64'(dispatch_idx), 64'(0));
    pop_c();
    prev = '0;
    for (int i = 0; i < 40; i++) begin
      nxt = m_tail[IDX_W-1:0];
      cycle(1'b1, 7'($urandom), 5'($urandom), (i > 0), prev, $urandom, 1'b1, 1'b0);
      prev = nxt;
    end
    chk("steady_count", 64'(rob_count), 64'(15));
    cdb(prev, $urandom);
    for (int i = 0; i < DEPTH; i++) pop_c();

    // CDB to an empty slot and duplicate CDB to a ready slot are ignored.
    disp(7'h13, 5'd7);
    t = q[0];
    cdb(IDX_W'(t + 1), 32'h99);
    cdb(IDX_W'(t), 32'h11);
    cdb(IDX_W'(t), 32'h22);
    chk("dup_cdb_value", 64'(commit_value), 64'h11);
    pop_c();

    // Flush beats simultaneous dispatch, CDB and pop.
    for (int i = 0; i < 5; i++) disp(7'($urandom), 5'($urandom));
    cdb(IDX_W'(q[1]), 32'h5);
    cycle(1'b1, 7'h33, 5'd3, 1'b1, IDX_W'(q[2]), 32'h66, 1'b1, 1'b1);
    chk("flush_count", 64'(rob_count), 64'(0));
    chk("flush_valid", 64'(rob_valid), 64'(0));
    chk("flush_idx", 64'(dispatch_idx), 64'(0));

    // Asynchronous reset between edges with entries in flight.
    for (int i = 0; i < 4; i++) disp(7'($urandom), 5'($urandom));
    cdb(IDX_W'(q[0]), 32'h1234);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state();
    disp(7'h33, 5'd9);
    cdb(IDX_W'(q[0]), 32'hCAFE);
    pop_c();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
